// File: rtl/chan_packet_fir_coef_loader_pkg.sv
// Shared constants and state encoding for the FIR coefficient loader.
// The b12/b13 coefficient pair arrives packed in one 32-bit register word.
package chan_packet_fir_pkg;

  localparam int COEF_W  = 16;
  localparam int WORD_W  = 2 * COEF_W;

  localparam int B12_MSB = 31;
  localparam int B12_LSB = 16;
  localparam int B13_MSB = 15;
  localparam int B13_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    PEND = 2'd2
  } qual_state_e;

endpackage

// File: rtl/chan_packet_fir_coef_loader_if.sv
// Register-word / sync / coefficient bundle between the register block and the FIR taps.
// Optional feature macro: FIR_COEF_UPD_CNT_EN adds the upd_count commit counter.
interface chan_packet_fir_coef_loader_if
  import chan_packet_fir_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic [WORD_W-1:0] reg_data_in;
  logic              sync_in;
  logic              sync_out;
  logic [COEF_W-1:0] coef_b12;
  logic [COEF_W-1:0] coef_b13;
  logic              coef_valid;
  logic              update_pending;
`ifdef FIR_COEF_UPD_CNT_EN
  logic [CNT_W-1:0]  upd_count;
`endif

  // Register side: drives the word and frame sync, observes the active pair.
  modport master (
    output reg_data_in, sync_in,
    input  sync_out, coef_b12, coef_b13, coef_valid, update_pending
`ifdef FIR_COEF_UPD_CNT_EN
    , input upd_count
`endif
  );

  // Loader side.
  modport slave (
    input  reg_data_in, sync_in,
    output sync_out, coef_b12, coef_b13, coef_valid, update_pending
`ifdef FIR_COEF_UPD_CNT_EN
    , output upd_count
`endif
  );

endinterface

// File: rtl/chan_packet_fir_coef_loader_qual.sv
// Stability qualifier: registers the incoming word, tracks a candidate that
// differs from the active pair, and flags it pending once it has held for
// STABLE_CYCLES. A sync while pending hands the candidate off to the commit.
module chan_packet_fir_coef_qual
  import chan_packet_fir_pkg::*;
#(
  parameter int STABLE_CYCLES = 2
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [WORD_W-1:0] i_reg_data,
  input  logic [WORD_W-1:0] i_active,
  input  logic              i_sync,
  output logic [WORD_W-1:0] o_cand,
  output logic              o_pend
);

  localparam int          CQ_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CQ_W-1:0] CNT_LAST = CQ_W'(STABLE_CYCLES - 1);

  qual_state_e       r_state, w_nxt_state;
  logic [WORD_W-1:0] r_in_q;
  logic [WORD_W-1:0] r_cand, w_nxt_cand;
  logic [CQ_W-1:0]   r_cnt, w_nxt_cnt;

  // State, candidate and stability counter registers; in_q tracks the input every cycle.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state <= IDLE;
      r_in_q  <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_in_q  <= i_reg_data;
      r_cand  <= w_nxt_cand;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next-state: a differing word restarts qualification; sync wins over a late change in PEND.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cand  = r_cand;
    w_nxt_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_in_q != i_active) begin
          w_nxt_cand  = r_in_q;
          w_nxt_cnt   = '0;
          w_nxt_state = QUAL;
        end
      end
      QUAL: begin
        if (r_in_q == i_active) begin
          w_nxt_state = IDLE;
        end else if (r_in_q != r_cand) begin
          w_nxt_cand = r_in_q;
          w_nxt_cnt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_nxt_state = PEND;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      PEND: begin
        if (i_sync) begin
          w_nxt_state = IDLE;
        end else if (r_in_q != r_cand) begin
          w_nxt_cand  = r_in_q;
          w_nxt_cnt   = '0;
          w_nxt_state = QUAL;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  assign o_cand = r_cand;
  assign o_pend = (r_state == PEND);

endmodule

// File: rtl/chan_packet_fir_coef_loader.sv
// FIR b12/b13 coefficient loader: qualifies a new register word as stable and
// commits the pair atomically on the channelizer frame sync.
// Optional feature macro: FIR_COEF_UPD_CNT_EN adds a wrapping commit counter (upd_count).
module chan_packet_fir_coef_loader
  import chan_packet_fir_pkg::*;
#(
  parameter int              STABLE_CYCLES = 2,
  parameter logic [COEF_W-1:0] RESET_B12   = 16'h0,
  parameter logic [COEF_W-1:0] RESET_B13   = 16'h0,
  parameter int              CNT_W         = 16
) (
  input  logic                   user_clk,
  input  logic                   user_rst,
  chan_packet_fir_coef_loader_if.slave bus
);

  logic [COEF_W-1:0] r_b12, r_b13;
  logic              r_valid;
  logic              r_sync_out;
  logic [WORD_W-1:0] w_cand;
  logic              w_pend;
  logic              w_commit;

  chan_packet_fir_coef_qual #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_qual (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .i_reg_data (bus.reg_data_in),
    .i_active   ({r_b12, r_b13}),
    .i_sync     (bus.sync_in),
    .o_cand     (w_cand),
    .o_pend     (w_pend)
  );

  assign w_commit = w_pend & bus.sync_in;

  // Commit registers: both halves switch on the same edge, only on a qualified sync.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_b12   <= RESET_B12;
      r_b13   <= RESET_B13;
      r_valid <= 1'b0;
    end else if (w_commit) begin
      r_b12   <= w_cand[B12_MSB:B12_LSB];
      r_b13   <= w_cand[B13_MSB:B13_LSB];
      r_valid <= 1'b1;
    end
  end

  // Sync delayed one cycle so it lines up with the coefficient switch.
  always_ff @(posedge user_clk) begin
    if (user_rst) r_sync_out <= 1'b0;
    else          r_sync_out <= bus.sync_in;
  end

  assign bus.coef_b12       = r_b12;
  assign bus.coef_b13       = r_b13;
  assign bus.coef_valid     = r_valid;
  assign bus.update_pending = w_pend;
  assign bus.sync_out       = r_sync_out;

`ifdef FIR_COEF_UPD_CNT_EN
  logic [CNT_W-1:0] r_upd_cnt;

  // Commit counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge user_clk) begin
    if (user_rst)      r_upd_cnt <= '0;
    else if (w_commit) r_upd_cnt <= r_upd_cnt + 1'b1;
  end

  assign bus.upd_count = r_upd_cnt;
`endif

endmodule

// File: tb/tb_chan_packet_fir_coef_loader.sv
// Bench for chan_packet_fir_coef_loader: directed scenarios plus random words/syncs/resets,
// every cycle compared against a run-length model of the qualification rules.
module tb_chan_packet_fir_coef_loader;
  import chan_packet_fir_pkg::*;

  localparam int S     = 2;
  localparam int CNT_W = 2;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  always #5 user_clk = ~user_clk;

  chan_packet_fir_coef_loader_if #(.CNT_W(CNT_W)) bus ();

  chan_packet_fir_coef_loader #(
    .STABLE_CYCLES (S),
    .RESET_B12     (16'h0),
    .RESET_B13     (16'h0),
    .CNT_W         (CNT_W)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: a word is pending once it has been the registered input, differing from the
  // active pair, for S+1 consecutive cycles since the last commit.
  logic [31:0]      m_inq, m_act, m_word;
  int               m_len;
  logic             m_valid, m_sync_q;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend();
    return m_len >= S + 1;
  endfunction

  task automatic model_step(input logic [31:0] d, input logic s, input logic r);
    if (r) begin
      m_inq = '0; m_act = '0; m_word = '0; m_len = 0;
      m_valid = 1'b0; m_sync_q = 1'b0; m_cnt = '0;
    end else begin
      if (m_pend() && s) begin
        m_act   = m_word;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 1'b1;
        m_len   = 0;
      end else if (m_inq != m_act) begin
        if (m_len > 0 && m_inq == m_word) m_len++;
        else begin m_word = m_inq; m_len = 1; end
      end else begin
        m_len = 0;
      end
      m_sync_q = s;
      m_inq    = d;
    end
  endtask

  // One cycle: drive, clock, update model, then compare all outputs.
  task automatic tick(input logic [31:0] d, input logic s, input logic r);
    bus.reg_data_in = d;
    bus.sync_in     = s;
    user_rst        = r;
    @(posedge user_clk);
    model_step(d, s, r);
    #1;
    chk("coef_b12", {16'h0, bus.coef_b12}, {16'h0, m_act[31:16]});
    chk("coef_b13", {16'h0, bus.coef_b13}, {16'h0, m_act[15:0]});
    chk("coef_valid", {31'h0, bus.coef_valid}, {31'h0, m_valid});
    chk("update_pending", {31'h0, bus.update_pending}, {31'h0, m_pend()});
    chk("sync_out", {31'h0, bus.sync_out}, {31'h0, m_sync_q});
`ifdef FIR_COEF_UPD_CNT_EN
    chk("upd_count", {{(32-CNT_W){1'b0}}, bus.upd_count}, {{(32-CNT_W){1'b0}}, m_cnt});
`endif
  endtask

  task automatic hold(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) tick(d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int          len;
    logic [1:0]  exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;

    // Reset, static zero input with sync pulses: nothing commits.
    tick(32'h0, 1'b0, 1'b1);
    tick(32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(32'h0, 1'b1, 1'b0);
      tick(32'h0, 1'b0, 1'b0);
    end
    chk("static_valid", {31'h0, bus.coef_valid}, 32'h0);
    chk("static_b12", {16'h0, bus.coef_b12}, 32'h0);

    // Held word: pending at t+4, committed by sync at t+10.
    hold(32'h1234_ABCD, 3);
    chk("pend_t3", {31'h0, bus.update_pending}, 32'h0);
    hold(32'h1234_ABCD, 1);
    chk("pend_t4", {31'h0, bus.update_pending}, 32'h1);
    hold(32'h1234_ABCD, 6);
    tick(32'h1234_ABCD, 1'b1, 1'b0);
    chk("commit_b12", {16'h0, bus.coef_b12}, 32'h0000_1234);
    chk("commit_b13", {16'h0, bus.coef_b13}, 32'h0000_ABCD);
    chk("commit_valid", {31'h0, bus.coef_valid}, 32'h1);
    chk("commit_sync_out", {31'h0, bus.sync_out}, 32'h1);

    // Toggling word never reaches PEND; only the final word commits.
    for (int i = 0; i < 10; i++) begin
      tick(32'hA5A5_0000 + 32'(i), (i % 3) == 0, 1'b0);
      chk("toggle_nopend", {31'h0, bus.update_pending}, 32'h0);
    end
    hold(32'hA5A5_0009, 2);
    chk("toggle_pend_early", {31'h0, bus.update_pending}, 32'h0);
    hold(32'hA5A5_0009, 1);
    chk("toggle_pend", {31'h0, bus.update_pending}, 32'h1);
    tick(32'hA5A5_0009, 1'b1, 1'b0);
    chk("toggle_b13", {16'h0, bus.coef_b13}, 32'h0000_0009);

    // Word change racing the sync: the qualified word still commits.
    hold(32'h1111_2222, 4);
    chk("race_pend", {31'h0, bus.update_pending}, 32'h1);
    tick(32'h3333_4444, 1'b1, 1'b0);
    chk("race_b12", {16'h0, bus.coef_b12}, 32'h0000_1111);
    chk("race_b13", {16'h0, bus.coef_b13}, 32'h0000_2222);
    hold(32'h3333_4444, 3);
    chk("race_pend2", {31'h0, bus.update_pending}, 32'h1);
    tick(32'h3333_4444, 1'b1, 1'b0);
    chk("race2_b12", {16'h0, bus.coef_b12}, 32'h0000_3333);
    chk("race2_b13", {16'h0, bus.coef_b13}, 32'h0000_4444);

    // Reset while pending discards the update.
    hold(32'hDEAD_BEEF, 4);
    tick(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("rst_b12", {16'h0, bus.coef_b12}, 32'h0);
    chk("rst_pend", {31'h0, bus.update_pending}, 32'h0);
    chk("rst_valid", {31'h0, bus.coef_valid}, 32'h0);
    tick(32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("rst_nocommit", {16'h0, bus.coef_b13}, 32'h0);
    hold(32'hDEAD_BEEF, 5);
    tick(32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("rst_requal", {16'h0, bus.coef_b13}, 32'h0000_BEEF);

`ifdef FIR_COEF_UPD_CNT_EN
    // Counter wraps at 2^CNT_W.
    tick(32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      hold(32'h0101_0101 * 32'(k + 1), 4);
      tick(32'h0101_0101 * 32'(k + 1), 1'b1, 1'b0);
      chk("upd_seq", {30'h0, bus.upd_count}, {30'h0, exp_cnt[k]});
    end
`endif

    // Random words drawn to hit active, near-duplicates and fresh values.
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 3))
        0:       w = 32'h0;
        1:       w = m_act;
        2:       w = {16'h00C0, 14'h0, 2'($urandom_range(0, 3))};
        default: w = $urandom;
      endcase
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        tick(w, $urandom_range(0, 5) == 0, $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
